// File: rtl/instr_encoder_if.sv
// Request/response bundle for the LEGv8 instruction encoder.
// The master side issues requests and consumes words. The slave side is the encoder.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [4:0]  rt;
    logic [4:0]  rn;
    logic [63:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;

    modport master (
        output in_valid, op, rt, rn, imm, out_ready,
        input  in_ready, out_valid, instr, err
    );

    modport slave (
        input  in_valid, op, rt, rn, imm, out_ready,
        output in_ready, out_valid, instr, err
    );
endinterface

// File: rtl/instr_encoder.sv
// Encodes LDUR/STUR/CBZ requests into single LEGv8 words.
// LOADCONST requests become a MOVZ/MOVK sequence with one word per nonzero halfword.
module instr_encoder (
    input  logic            clk,
    input  logic            reset,
    instr_encoder_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SINGLE = 2'd1,
        S_CONST  = 2'd2
    } state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_instr, w_instr_next;
    logic        r_out_valid, w_out_valid_next;
    logic        r_err, w_err_next;
    logic [3:0]  r_mask, w_mask_next;
    logic [63:0] r_imm, w_imm_next;
    logic [4:0]  r_rt, w_rt_next;

    logic [3:0]  w_in_nz;
    logic [1:0]  w_in_low;
    logic [15:0] w_in_hw;
    logic        w_in_multi;
    logic [1:0]  w_pend_low;
    logic [15:0] w_pend_hw;
    logic        w_accept;
    logic        w_out_hs;
    logic        w_ldst_ok;
    logic        w_cbz_ok;

    function automatic logic [1:0] f_lowest(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        if (m[0])      idx = 2'd0;
        else if (m[1]) idx = 2'd1;
        else if (m[2]) idx = 2'd2;
        else if (m[3]) idx = 2'd3;
        return idx;
    endfunction

    function automatic logic [31:0] f_mov(input logic movk, input logic [1:0] hw,
                                          input logic [15:0] val, input logic [4:0] rd);
        return {(movk ? 9'b111100101 : 9'b110100101), hw, val, rd};
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_hw_nz
            assign w_in_nz[gi] = |bus.imm[16*gi +: 16];
        end
    endgenerate

    assign w_in_low   = f_lowest(w_in_nz);
    assign w_in_hw    = bus.imm[{w_in_low, 4'b0000} +: 16];
    assign w_in_multi = (w_in_nz & (w_in_nz - 4'd1)) != 4'd0;
    assign w_pend_low = f_lowest(r_mask);
    assign w_pend_hw  = r_imm[{w_pend_low, 4'b0000} +: 16];

    // In range exactly when every bit above the field equals the field's sign bit.
    assign w_ldst_ok = (bus.imm[63:8]  == {56{bus.imm[8]}});
    assign w_cbz_ok  = (bus.imm[63:18] == {46{bus.imm[18]}});

    assign bus.in_ready  = reset && (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign w_out_hs      = r_out_valid && bus.out_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.instr     = r_instr;
    assign bus.err       = r_err;

    always_comb begin
        w_state_next     = r_state;
        w_instr_next     = r_instr;
        w_out_valid_next = r_out_valid;
        w_err_next       = 1'b0;
        w_mask_next      = r_mask;
        w_imm_next       = r_imm;
        w_rt_next        = r_rt;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_imm_next = bus.imm;
                    w_rt_next  = bus.rt;
                    case (bus.op)
                        2'b00, 2'b01: begin
                            if (w_ldst_ok) begin
                                w_instr_next     = {(bus.op[0] ? 11'b11111000000 : 11'b11111000010),
                                                    bus.imm[8:0], 2'b00, bus.rn, bus.rt};
                                w_out_valid_next = 1'b1;
                                w_state_next     = S_SINGLE;
                            end else begin
                                w_err_next = 1'b1;
                            end
                        end
                        2'b10: begin
                            if (w_cbz_ok) begin
                                w_instr_next     = {8'b10110100, bus.imm[18:0], bus.rt};
                                w_out_valid_next = 1'b1;
                                w_state_next     = S_SINGLE;
                            end else begin
                                w_err_next = 1'b1;
                            end
                        end
                        default: begin
                            // An all-zero constant falls out as MOVZ hw=0 imm16=0.
                            w_instr_next     = f_mov(1'b0, w_in_low, w_in_hw, bus.rt);
                            w_out_valid_next = 1'b1;
                            if (w_in_multi) begin
                                w_mask_next  = w_in_nz & ~(4'b0001 << w_in_low);
                                w_state_next = S_CONST;
                            end else begin
                                w_mask_next  = 4'd0;
                                w_state_next = S_SINGLE;
                            end
                        end
                    endcase
                end
            end
            S_SINGLE: begin
                if (w_out_hs) begin
                    w_out_valid_next = 1'b0;
                    w_state_next     = S_IDLE;
                end
            end
            S_CONST: begin
                // r_mask holds halfwords not yet shown; the word on instr is already out.
                if (w_out_hs) begin
                    if (r_mask != 4'd0) begin
                        w_instr_next = f_mov(1'b1, w_pend_low, w_pend_hw, r_rt);
                        w_mask_next  = r_mask & ~(4'b0001 << w_pend_low);
                    end else begin
                        w_out_valid_next = 1'b0;
                        w_state_next     = S_IDLE;
                    end
                end
            end
            default: begin
                w_out_valid_next = 1'b0;
                w_mask_next      = 4'd0;
                w_state_next     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_instr     <= 32'h0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_mask      <= 4'd0;
            r_imm       <= 64'h0;
            r_rt        <= 5'd0;
        end else begin
            r_state     <= w_state_next;
            r_instr     <= w_instr_next;
            r_out_valid <= w_out_valid_next;
            r_err       <= w_err_next;
            r_mask      <= w_mask_next;
            r_imm       <= w_imm_next;
            r_rt        <= w_rt_next;
        end
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have no parameters; widths are fixed as listed.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; asserted (0) forces reset state immediately; released synchronously to clk.
REQ-004 in_valid  in  1  request present.
REQ-005 in_ready  out  1  request accepted on a clk edge where in_valid && in_ready.
REQ-006 op  in  2  00 LDUR, 01 STUR, 10 CBZ, 11 LOADCONST.
REQ-007 rt  in  5  Rt (LDUR/STUR/CBZ) or Rd (LOADCONST).
REQ-008 rn  in  5  base register for LDUR/STUR; ignored otherwise.
REQ-009 imm  in  64  two's-complement offset (LDUR/STUR/CBZ) or 64-bit constant (LOADCONST).
REQ-010 out_valid  out  1  instr holds a valid LEGv8 word.
REQ-011 out_ready  in  1  consumer takes instr on a clk edge where out_valid && out_ready.
REQ-012 instr  out  32  encoded instruction word.
REQ-013 err  out  1  one-cycle pulse: accepted request had an out-of-range immediate.

Function
REQ-014 SHALL capture op, rt, rn and imm on acceptance; inputs are don't-care afterwards.
REQ-015 in_ready SHALL be 1 only in IDLE with (!out_valid || out_ready).
REQ-016 LDUR SHALL encode {11'b11111000010, imm[8:0], 2'b00, rn, rt}; STUR identical with opcode 11'b11111000000.
REQ-017 LDUR/STUR range: imm in [-256, 255]; otherwise error.
REQ-018 CBZ SHALL encode {8'b10110100, imm[18:0], rt}; range: imm in [-2^18, 2^18-1]; otherwise error.
REQ-019 Error: no word emitted, out_valid stays 0, err = 1 for exactly the cycle after acceptance, FSM stays in IDLE.
REQ-020 LOADCONST SHALL emit MOVZ {9'b110100101, hw, imm16, rt} for the lowest-index nonzero halfword, then MOVK {9'b111100101, hw, imm16, rt} for each remaining nonzero halfword in ascending hw order; hw in 0..3, imm16 = imm[16*hw+15:16*hw].
REQ-021 LOADCONST with imm == 0 SHALL emit exactly one MOVZ with hw=0, imm16=0.
REQ-022 LOADCONST emits 1..4 words; never emits a word for a zero halfword other than REQ-021's case.
REQ-023 FSM states: IDLE, SINGLE (one word pending), CONST (multi-word walk holding a 4-bit pending-halfword mask).
REQ-024 Transitions: IDLE->SINGLE on accepted valid LDUR/STUR/CBZ or single-word LOADCONST; IDLE->CONST on LOADCONST with >=2 nonzero halfwords; SINGLE->IDLE on handshake; CONST->CONST on handshake with mask bits remaining; CONST->IDLE on handshake of last word.
REQ-025 Latency: first word valid on the edge after acceptance; each further LOADCONST word valid on the edge after the previous handshake (one word per cycle with out_ready held high).
REQ-026 While out_valid && !out_ready, instr SHALL remain stable and no state SHALL advance.
REQ-027 Back-to-back: a new request MAY be accepted in the same cycle as the final word's handshake; its first word appears the next cycle.

Reset
REQ-028 On reset assertion: state IDLE, out_valid 0, instr 32'h0, err 0, mask 0; any in-progress sequence abandoned, no partial word emitted after release.
REQ-029 in_ready SHALL be 0 while reset is asserted and 1 in the first cycle after release.

Verification
REQ-030 LDUR rt=1 rn=2 imm=8, out_ready=1 -> next cycle out_valid=1, instr=32'hF8408041, err=0.
REQ-031 CBZ rt=3 imm=-2 -> instr=32'hB4FFFFC3.
REQ-032 LOADCONST rt=5 imm=64'h0000_1234_0000_ABCD, out_ready=1 -> instr 32'hD29579A5 then 32'hF2C24685 on consecutive cycles, then out_valid=0; in_ready=0 throughout sequence.
REQ-033 LDUR imm=256 -> err=1 for one cycle, out_valid never 1, in_ready=1 the following cycle.
REQ-034 REQ-032 stimulus with out_ready=0 for 3 cycles on the first word -> instr holds 32'hD29579A5 all 3 cycles; second word follows the first handshake.
REQ-035 Reset asserted between the two words of REQ-032 -> out_valid=0, instr=0 immediately; after release no MOVK emitted, in_ready=1.
